wide_add_ctrl: RTL and testbench
================================

WIDE_ADD_CTRL -- requirements
Module: wide_add_ctrl

Interface
REQ-001 SHALL have parameter NWORDS, default 4, giving the number of 32-bit words per operand; legal values are 1 to 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: request present.
REQ-005 SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-006 SHALL have port req_a, input, 32*NWORDS bits: operand A; word 0 is bits [31:0].
REQ-007 SHALL have port req_b, input, 32*NWORDS bits: operand B.
REQ-008 SHALL have port req_sub, input, 1 bit: 1 = A-B, 0 = A+B+req_cin.
REQ-009 SHALL have port req_cin, input, 1 bit: carry-in, used only when req_sub=0.
REQ-010 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port rsp_sum, output, 32*NWORDS bits: result.
REQ-013 SHALL have port rsp_cout, output, 1 bit: carry out of the top word; for subtract, 0 means borrow.
REQ-014 SHALL have port rsp_ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 SHALL have ports add_a and add_b, outputs, 32 bits each: operands driven to the shared 32-bit adder.
REQ-016 SHALL have port add_cin, output, 1 bit: carry-in driven to the shared adder.
REQ-017 SHALL have port add_sum, input, 32 bits: sum returned combinationally by the shared adder in the same cycle.
REQ-018 SHALL have port add_cout, input, 1 bit: carry returned combinationally by the shared adder in the same cycle.

Function
REQ-019 SHALL implement an FSM with states IDLE, RUN and DONE; req_ready=1 only in IDLE, and rsp_valid=1 only in DONE.
REQ-020 SHALL, when in IDLE with req_valid=1 at a clock edge (the accept edge), do all of the following:
- latch req_a and req_b;
- latch the effective B, which is ~req_b when req_sub=1;
- set the carry register to 1 when req_sub=1, otherwise to req_cin;
- clear the word index;
- enter RUN.
REQ-021 SHALL, in RUN, drive the shared adder combinationally:
- add_a = latched A word[idx];
- add_b = effective B word[idx];
- add_cin = carry register.
REQ-022 SHALL, at each RUN edge, write add_sum into result word[idx], load add_cout into the carry register, and increment idx.
REQ-023 SHALL move to DONE at the edge that processes word NWORDS-1; RUN therefore lasts exactly NWORDS cycles.
REQ-024 SHALL assert rsp_valid exactly NWORDS cycles after the accept edge.
REQ-025 SHALL set rsp_cout to the final carry.
REQ-026 SHALL compute rsp_ovf from bit 31 of the top word: ovf = (A msb == effective-B msb) AND (sum msb != A msb).
REQ-027 SHALL hold rsp_sum, rsp_cout and rsp_ovf stable while rsp_valid=1, and keep them until the next RUN overwrites them.
REQ-028 SHALL, in DONE, remain in DONE until rsp_ready=1, and go to IDLE on that edge; back-to-back acceptance in DONE is not supported.
REQ-029 SHALL drive add_a, add_b and add_cin to 0 in IDLE and DONE.
REQ-030 SHALL ignore req_valid outside IDLE, and ignore rsp_ready outside DONE.
REQ-031 SHALL ignore changes to the req_* inputs after the accept edge.
REQ-032 SHALL, with NWORDS=1, spend one RUN cycle and assert rsp_valid one cycle after the accept edge.
REQ-033 SHALL wrap the carry naturally: an all-ones word plus carry gives result word 0 and a carry into the next word.

Reset
REQ-034 SHALL, on rst=1, immediately and asynchronously set the state to IDLE and clear idx and the carry register.
REQ-035 SHALL, on rst=1, clear rsp_sum, rsp_cout and rsp_ovf to 0; rsp_valid=0 and req_ready=1 follow from IDLE.
REQ-036 SHALL, on reset during RUN or DONE, discard the operation; no response is ever produced for it.
REQ-037 SHALL be ready to accept a request on the first clock edge after rst deasserts.

Verification (NWORDS=4; the bench models the shared adder as a behavioural 32-bit add)
REQ-038 SHALL cover: add with A=all-ones, B=0, cin=1, rsp_ready=1 -> rsp_sum=0, cout=1, ovf=0, rsp_valid exactly 4 cycles after the accept edge.
REQ-039 SHALL cover: sub with A=0, B=1 -> rsp_sum=all-ones, cout=0, ovf=0; and add_cin=1 on the first RUN cycle.
REQ-040 SHALL cover: add with A=0x7FFF..FF, B=1, cin=0 -> rsp_sum=0x8000..00, ovf=1, cout=0.
REQ-041 SHALL cover: rsp_ready held low 3 cycles after rsp_valid while req_valid=1 -> rsp_valid stays 1, outputs stay stable, req_ready=0, and the new request is accepted only after the handshake.
REQ-042 SHALL cover: rst pulsed after 2 RUN cycles -> rsp_valid=0 and req_ready=1 at once, no response appears, and the next request (A=5, B=3) yields 8.
REQ-043 SHALL cover: 10000 random requests (random req_sub/req_cin, random rsp_ready stalls) -> every result equals the 129-bit reference model, with a pass message at the end.

Source files
------------

// File: rtl/wide_add_ctrl.sv
// Word-serial wide adder/subtractor controller: streams NWORDS 32-bit words
// through one external shared 32-bit adder, LSW first, carrying between words.
module wide_add_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [32*NWORDS-1:0] req_a,
  input  logic [32*NWORDS-1:0] req_b,
  input  logic                 req_sub,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [32*NWORDS-1:0] rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_cin,
  input  logic [31:0]          add_sum,
  input  logic                 add_cout
);

  localparam int W    = 32 * NWORDS;
  localparam int IDXW = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic              carry_q;
  logic              cout_q;
  logic              ovf_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [IDXW-1:0]   idx_q;

  logic [31:0]       a_words [NWORDS];
  logic [31:0]       b_words [NWORDS];
  logic [31:0]       a_word_d;
  logic [31:0]       b_word_d;
  logic              last_word_d;

  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
    assign a_words[gi] = a_q[gi*32 +: 32];
    assign b_words[gi] = b_q[gi*32 +: 32];
  end

  // Word selection as a one-hot mux so the index never reaches past NWORDS.
  always_comb begin
    a_word_d = '0;
    b_word_d = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_word_d = a_words[i];
        b_word_d = b_words[i];
      end
    end
  end

  assign last_word_d = (idx_q == IDXW'(NWORDS - 1));

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_word_d;
      add_b   = b_word_d;
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      idx_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // Subtraction is A + ~B + 1, so B is inverted once at accept time.
            a_q         <= req_a;
            b_q         <= req_sub ? ~req_b : req_b;
            carry_q     <= req_sub ? 1'b1 : req_cin;
            idx_q       <= '0;
            state_q     <= RUN;
            req_ready_q <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < NWORDS; i++) begin
            if (idx_q == IDXW'(i)) sum_q[i*32 +: 32] <= add_sum;
          end
          carry_q <= add_cout;
          idx_q   <= idx_q + IDXW'(1);
          if (last_word_d) begin
            cout_q      <= add_cout;
            ovf_q       <= (a_q[W-1] == b_q[W-1]) && (add_sum[31] != a_q[W-1]);
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_ctrl.sv
// Directed and random checks of wide_add_ctrl with NWORDS=4 and a behavioural
// shared 32-bit adder.
module tb_wide_add_ctrl;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          req_sub;
  logic          req_cin;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_sum;
  logic          rsp_cout;
  logic          rsp_ovf;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic          add_cin;
  logic [31:0]   add_sum;
  logic          add_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  wide_add_ctrl #(.NWORDS(NW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_sub  (req_sub),
    .req_cin  (req_cin),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout),
    .rsp_ovf  (rsp_ovf),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request while IDLE and returns just after the accept edge.
  task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic cin);
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    req_cin   = cin;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          rand_fail_start;
    logic        saw_valid;
    logic [W-1:0] ra, rb, effb;
    logic        rsub, rcin, rc;
    logic [W:0]  ref_v;
    logic        ref_ovf;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_sub = 1'b0; req_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_outputs", {rsp_cout, rsp_ovf, rsp_sum}, '0);
    chk("reset_adder_ports", {add_a, add_b, add_cin}, '0);
    rst = 1'b0;

    // All-ones + 0 + cin=1 ripples the carry through every word.
    rsp_ready = 1'b1;
    start_req({W{1'b1}}, '0, 1'b0, 1'b1);
    rsp_ready = 1'b1;
    chk("t1_ready_low_in_run", req_ready, 1'b0);
    wait_valid(cyc);
    chk("t1_latency", cyc, 4);
    chk("t1_sum", rsp_sum, '0);
    chk("t1_cout_ovf", {rsp_cout, rsp_ovf}, 2'b10);
    tick();
    rsp_ready = 1'b0;
    chk("t1_back_idle", {rsp_valid, req_ready}, 2'b01);

    // 0 - 1: first RUN cycle sees inverted B and carry-in 1.
    start_req('0, 128'd1, 1'b1, 1'b0);
    chk("t2_first_run_adder", {add_a, add_b, add_cin}, {32'h0, 32'hFFFF_FFFE, 1'b1});
    wait_valid(cyc);
    chk("t2_latency", cyc, 4);
    chk("t2_sum", rsp_sum, {W{1'b1}});
    chk("t2_cout_ovf", {rsp_cout, rsp_ovf}, 2'b00);
    handshake();

    // Largest positive + 1 overflows into the sign bit.
    start_req({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0);
    wait_valid(cyc);
    chk("t3_sum", rsp_sum, {1'b1, {(W-1){1'b0}}});
    chk("t3_cout_ovf", {rsp_cout, rsp_ovf}, 2'b01);
    handshake();

    // Stalled response with a pending request; inputs change after accept.
    req_a = 128'd3; req_b = 128'd4; req_sub = 1'b0; req_cin = 1'b0;
    req_valid = 1'b1;
    tick();
    req_a = 128'd10; req_b = 128'd20;
    wait_valid(cyc);
    chk("t4_latency", cyc, 4);
    chk("t4_sum_first", rsp_sum, 128'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_hold", {rsp_valid, req_ready, rsp_cout, rsp_ovf, rsp_sum},
          {1'b1, 1'b0, 1'b0, 1'b0, 128'd7});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t4_after_handshake", {rsp_valid, req_ready}, 2'b01);
    tick();
    req_valid = 1'b0;
    chk("t4_second_accepted", req_ready, 1'b0);
    wait_valid(cyc);
    chk("t4_second_latency", cyc, 4);
    chk("t4_sum_second", rsp_sum, 128'd30);
    handshake();

    // Reset in the middle of RUN discards the operation.
    start_req(128'd1, 128'd1, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_reset_flags", {rsp_valid, req_ready}, 2'b01);
    chk("t5_reset_outputs", {rsp_cout, rsp_ovf, rsp_sum}, '0);
    #2;
    rst = 1'b0;
    saw_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) saw_valid = 1'b1;
    end
    rsp_ready = 1'b0;
    chk("t5_no_response", saw_valid, 1'b0);
    start_req(128'd5, 128'd3, 1'b0, 1'b0);
    wait_valid(cyc);
    chk("t5_latency", cyc, 4);
    chk("t5_sum", rsp_sum, 128'd8);
    handshake();

    // Random requests against a full-width reference add.
    rand_fail_start = failures;
    for (int n = 0; n < 10000; n++) begin
      ra   = {$urandom, $urandom, $urandom, $urandom};
      rb   = {$urandom, $urandom, $urandom, $urandom};
      rsub = 1'($urandom_range(1));
      rcin = 1'($urandom_range(1));
      effb = rsub ? ~rb : rb;
      rc   = rsub ? 1'b1 : rcin;
      ref_v   = {1'b0, ra} + {1'b0, effb} + {{W{1'b0}}, rc};
      ref_ovf = (ra[W-1] == effb[W-1]) && (ref_v[W-1] != ra[W-1]);
      rsp_ready = ($urandom_range(7) != 0);
      start_req(ra, rb, rsub, rcin);
      wait_valid(cyc);
      if (!rsp_valid) begin
        chk("rand_timeout", rsp_valid, 1'b1);
      end else begin
        if (!rsp_ready) begin
          tick();
          rsp_ready = 1'b1;
        end
        chk("rand_result", {rsp_cout, rsp_ovf, rsp_sum}, {ref_v[W], ref_ovf, ref_v[W-1:0]});
        tick();
      end
      rsp_ready = 1'b0;
    end
    if (failures == rand_fail_start)
      $display("random: 10000 requests matched the reference model");
    else
      $display("random: %0d of 10000 requests wrong", failures - rand_fail_start);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
